mc_control: RTL and testbench

- Multi-cycle RV32I control unit for the next NPC core generation.
- Replaces the single-cycle decode table with a state machine sequencing fetch, decode, execute, memory and writeback.
- Handshakes with the instruction and data memory ports, detects ebreak, illegal instructions and memory timeouts, and drives all datapath enables and selects per cycle.

---
 rtl/ctrl_pkg.sv | 74 +++++++
 rtl/ctrl_decode.sv | 109 ++++++++++
 rtl/mc_control.sv | 241 ++++++++++++++++++++++++
 tb/tb_mc_control.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Optional RV32M sequencing is enabled by defining MC_CTRL_MULDIV_EN.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC     = 4'd3,
        ST_MEM_REQ  = 4'd4,
        ST_MEM_WAIT = 4'd5,
        ST_WB       = 4'd6,
        ST_HALT     = 4'd7
`ifdef MC_CTRL_MULDIV_EN
        , ST_MD_WAIT = 4'd8
`endif
    } state_e;

    typedef enum logic [3:0] {
        K_ALU, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BRANCH,
        K_LOAD, K_STORE, K_FENCE, K_MULDIV
    } kind_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    localparam logic [2:0] WD_ALU   = 3'b000;
    localparam logic [2:0] WD_PC4   = 3'b001;
    localparam logic [2:0] WD_IMM   = 3'b010;
    localparam logic [2:0] WD_PCIMM = 3'b011;
    localparam logic [2:0] WD_MEM   = 3'b100;
    localparam logic [2:0] WD_MD    = 3'b101;

    localparam logic [1:0] PC_4   = 2'b00;
    localparam logic [1:0] PC_IMM = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef struct packed {
        kind_e      kind;
        logic [2:0] imm_src;
        logic       alu_src;
        logic [3:0] alu_ctr;
        logic [2:0] mem_op;
    } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational instruction decode into the control field bundle.
// RV32M encodings are accepted only when MC_CTRL_MULDIV_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] i_inst,
    output dec_t        o_dec,
    output logic        o_ebreak,
    output logic        o_illegal
);

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;

    assign w_op = i_inst[6:0];
    assign w_f3 = i_inst[14:12];
    assign w_f7 = i_inst[31:25];

    always_comb begin
        o_dec     = '0;
        o_ebreak  = 1'b0;
        o_illegal = 1'b0;
        case (w_op)
            OP_LUI: begin
                o_dec.kind    = K_LUI;
                o_dec.imm_src = IMM_U;
            end
            OP_AUIPC: begin
                o_dec.kind    = K_AUIPC;
                o_dec.imm_src = IMM_U;
            end
            OP_JAL: begin
                o_dec.kind    = K_JAL;
                o_dec.imm_src = IMM_J;
            end
            OP_JALR: begin
                o_dec.kind    = K_JALR;
                o_dec.imm_src = IMM_I;
                o_dec.alu_src = 1'b1;
                o_illegal     = (w_f3 != 3'b000);
            end
            OP_BRANCH: begin
                o_dec.kind    = K_BRANCH;
                o_dec.imm_src = IMM_B;
                case (w_f3)
                    3'b000, 3'b001: o_dec.alu_ctr = ALU_SUB;
                    3'b100, 3'b101: o_dec.alu_ctr = ALU_SLT;
                    3'b110, 3'b111: o_dec.alu_ctr = ALU_SLTU;
                    default:        o_illegal     = 1'b1;
                endcase
            end
            OP_LOAD: begin
                o_dec.kind    = K_LOAD;
                o_dec.imm_src = IMM_I;
                o_dec.alu_src = 1'b1;
                o_dec.mem_op  = w_f3;
                o_illegal     = !(w_f3 inside {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU});
            end
            OP_STORE: begin
                o_dec.kind    = K_STORE;
                o_dec.imm_src = IMM_S;
                o_dec.alu_src = 1'b1;
                o_dec.mem_op  = w_f3;
                o_illegal     = !(w_f3 inside {MEM_B, MEM_H, MEM_W});
            end
            OP_IMM: begin
                o_dec.kind    = K_ALU;
                o_dec.imm_src = IMM_I;
                o_dec.alu_src = 1'b1;
                o_dec.alu_ctr = {1'b0, w_f3};
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (w_f3 == 3'b001 && w_f7 != 7'b0000000) begin
                    o_illegal = 1'b1;
                end else if (w_f3 == 3'b101) begin
                    if (w_f7 == 7'b0100000) begin
                        o_dec.alu_ctr = 4'b1101;
                    end else if (w_f7 != 7'b0000000) begin
                        o_illegal = 1'b1;
                    end
                end
            end
            OP_REG: begin
                o_dec.kind = K_ALU;
                if (w_f7 == 7'b0000000) begin
                    o_dec.alu_ctr = {1'b0, w_f3};
                end else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
                    o_dec.alu_ctr = {1'b1, w_f3};
`ifdef MC_CTRL_MULDIV_EN
                end else if (w_f7 == 7'b0000001) begin
                    o_dec.kind = K_MULDIV;
`endif
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OP_FENCE: begin
                o_dec.kind = K_FENCE;
                o_illegal  = (w_f3 != 3'b000);
            end
            OP_SYSTEM: begin
                o_ebreak  = (i_inst == EBREAK);
                o_illegal = (i_inst != EBREAK);
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing.
// Define MC_CTRL_MULDIV_EN to add the md_start/md_done handshake and MD_WAIT state.
module mc_control
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        br_taken,
    output logic        imem_req_valid,
    input  logic        imem_resp_valid,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    input  logic        dmem_resp_valid,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [2:0]  imm_src,
    output logic        alu_src,
    output logic [3:0]  alu_ctr,
    output logic        mem_write,
    output logic [2:0]  mem_op,
    output logic [2:0]  wd_src,
`ifdef MC_CTRL_MULDIV_EN
    output logic        md_start,
    input  logic        md_done,
`endif
    output logic [3:0]  state,
    output logic        halt,
    output logic        illegal,
    output logic        bus_err
);

    localparam int               CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    dec_t             r_dec;
    dec_t             w_dec;
    logic             w_ebreak;
    logic             w_illegal;
    logic             r_halt;
    logic             r_illegal;
    logic             r_bus_err;
    logic             w_waiting;
    logic             w_handshake;
    logic             w_timeout;
    logic             w_store;

    ctrl_decode u_decode (
        .i_inst    (inst),
        .o_dec     (w_dec),
        .o_ebreak  (w_ebreak),
        .o_illegal (w_illegal)
    );

    assign w_store = (r_dec.kind == K_STORE);

    // Which handshake the current state is waiting on; the limit cycle still honours a late handshake.
    always_comb begin
        w_waiting   = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_waiting   = 1'b1;
                w_handshake = imem_resp_valid;
            end
            ST_MEM_REQ: begin
                w_waiting   = 1'b1;
                w_handshake = dmem_req_ready;
            end
            ST_MEM_WAIT: begin
                w_waiting   = 1'b1;
                w_handshake = dmem_resp_valid;
            end
`ifdef MC_CTRL_MULDIV_EN
            ST_MD_WAIT: begin
                w_waiting   = 1'b1;
                w_handshake = md_done;
            end
`endif
            default: ;
        endcase
        w_timeout = w_waiting && !w_handshake && (r_wait_cnt == LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   w_next = ST_FETCH;
            ST_FETCH: begin
                if (w_handshake)    w_next = ST_DECODE;
                else if (w_timeout) w_next = ST_HALT;
            end
            ST_DECODE: w_next = (w_ebreak || w_illegal) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                case (r_dec.kind)
                    K_BRANCH, K_JAL, K_JALR: w_next = ST_FETCH;
                    K_LOAD, K_STORE:         w_next = ST_MEM_REQ;
`ifdef MC_CTRL_MULDIV_EN
                    K_MULDIV:                w_next = ST_MD_WAIT;
`endif
                    default:                 w_next = ST_WB;
                endcase
            end
            ST_MEM_REQ: begin
                if (w_handshake)    w_next = w_store ? ST_FETCH : ST_MEM_WAIT;
                else if (w_timeout) w_next = ST_HALT;
            end
            ST_MEM_WAIT: begin
                if (w_handshake)    w_next = ST_FETCH;
                else if (w_timeout) w_next = ST_HALT;
            end
`ifdef MC_CTRL_MULDIV_EN
            ST_MD_WAIT: begin
                if (w_handshake)    w_next = ST_WB;
                else if (w_timeout) w_next = ST_HALT;
            end
`endif
            ST_WB:     w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_halt     <= 1'b0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_waiting && !w_handshake) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if (r_state == ST_DECODE && w_ebreak)  r_halt    <= 1'b1;
            if (r_state == ST_DECODE && w_illegal) r_illegal <= 1'b1;
            if (w_timeout)                          r_bus_err <= 1'b1;
        end
    end

    // Decoded fields are datapath-side: captured once in DECODE, no reset needed.
    always_ff @(posedge clk) begin
        if (r_state == ST_DECODE) begin
            r_dec <= w_dec;
        end
    end

    always_comb begin
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        pc_src         = PC_4;
        reg_write      = 1'b0;
        imm_src        = IMM_I;
        alu_src        = 1'b0;
        alu_ctr        = ALU_ADD;
        mem_write      = 1'b0;
        mem_op         = MEM_B;
        wd_src         = WD_ALU;
`ifdef MC_CTRL_MULDIV_EN
        md_start       = 1'b0;
`endif
        if (!(r_state inside {ST_IDLE, ST_FETCH, ST_DECODE, ST_HALT})) begin
            imm_src = r_dec.imm_src;
            alu_src = r_dec.alu_src;
            alu_ctr = r_dec.alu_ctr;
        end
        case (r_state)
            ST_FETCH: begin
                imem_req_valid = 1'b1;
                ir_write       = imem_resp_valid;
            end
            ST_EXEC: begin
                case (r_dec.kind)
                    K_BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = br_taken ? PC_IMM : PC_4;
                    end
                    K_JAL, K_JALR: begin
                        reg_write = 1'b1;
                        wd_src    = WD_PC4;
                        pc_write  = 1'b1;
                        pc_src    = (r_dec.kind == K_JAL) ? PC_IMM : PC_REG;
                    end
`ifdef MC_CTRL_MULDIV_EN
                    K_MULDIV: md_start = 1'b1;
`endif
                    default: ;
                endcase
            end
            ST_MEM_REQ: begin
                dmem_req_valid = 1'b1;
                mem_write      = w_store;
                mem_op         = r_dec.mem_op;
                pc_write       = w_store && dmem_req_ready;
            end
            ST_MEM_WAIT: begin
                mem_op = r_dec.mem_op;
                if (dmem_resp_valid) begin
                    reg_write = 1'b1;
                    wd_src    = WD_MEM;
                    pc_write  = 1'b1;
                end
            end
            ST_WB: begin
                reg_write = (r_dec.kind != K_FENCE);
                pc_write  = 1'b1;
                case (r_dec.kind)
                    K_LUI:    wd_src = WD_IMM;
                    K_AUIPC:  wd_src = WD_PCIMM;
                    K_MULDIV: wd_src = WD_MD;
                    default:  wd_src = WD_ALU;
                endcase
            end
            default: ;
        endcase
    end

    assign state   = r_state;
    assign halt    = r_halt;
    assign illegal = r_illegal;
    assign bus_err = r_bus_err;

endmodule

// File: tb/tb_mc_control.sv
// Directed testbench for mc_control (MEM_TIMEOUT=8) with immediate-assertion checks.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        br_taken;
    logic        imem_req_valid;
    logic        imem_resp_valid;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_resp_valid;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [2:0]  imm_src;
    logic        alu_src;
    logic [3:0]  alu_ctr;
    logic        mem_write;
    logic [2:0]  mem_op;
    logic [2:0]  wd_src;
    logic [3:0]  state;
    logic        halt;
    logic        illegal;
    logic        bus_err;
`ifdef MC_CTRL_MULDIV_EN
    logic        md_start;
    logic        md_done = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_control #(.MEM_TIMEOUT(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst            (inst),
        .br_taken        (br_taken),
        .imem_req_valid  (imem_req_valid),
        .imem_resp_valid (imem_resp_valid),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_resp_valid (dmem_resp_valid),
        .ir_write        (ir_write),
        .pc_write        (pc_write),
        .pc_src          (pc_src),
        .reg_write       (reg_write),
        .imm_src         (imm_src),
        .alu_src         (alu_src),
        .alu_ctr         (alu_ctr),
        .mem_write       (mem_write),
        .mem_op          (mem_op),
        .wd_src          (wd_src),
`ifdef MC_CTRL_MULDIV_EN
        .md_start        (md_start),
        .md_done         (md_done),
`endif
        .state           (state),
        .halt            (halt),
        .illegal         (illegal),
        .bus_err         (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents an instruction on a one-cycle fetch response; returns in DECODE.
    task automatic fetch(input logic [31:0] i);
        inst            = i;
        imem_resp_valid = 1'b1;
        #1;
        chk("fetch_ir_write", ir_write, 1);
        next_cycle();
        imem_resp_valid = 1'b0;
    endtask

    // Pulses reset mid-cycle and returns in the first FETCH cycle.
    task automatic do_reset();
        rst = 1'b1;
        imem_resp_valid = 1'b0;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        br_taken        = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        inst            = 32'h0;
        br_taken        = 1'b0;
        imem_resp_valid = 1'b0;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_enables", {imem_req_valid, dmem_req_valid, ir_write, pc_write, reg_write, mem_write}, 0);
        chk("rst_selects", {pc_src, imm_src, alu_src, alu_ctr, mem_op, wd_src}, 0);
        chk("rst_flags", {halt, illegal, bus_err}, 0);
        rst = 1'b0;
        #1;
        chk("idle_state", state, 0);
        next_cycle();
        chk("fetch_state", state, 1);
        chk("fetch_req", imem_req_valid, 1);
        chk("fetch_no_irw", ir_write, 0);

        // addi x1,x0,5
        fetch(32'h0050_0093);
        chk("addi_decode", state, 2);
        next_cycle();
        chk("addi_exec", state, 3);
        chk("addi_exec_regw", reg_write, 0);
        next_cycle();
        chk("addi_wb_state", state, 6);
        chk("addi_wb_regw", reg_write, 1);
        chk("addi_wb_alu_ctr", alu_ctr, 4'b0000);
        chk("addi_wb_alu_src", alu_src, 1);
        chk("addi_wb_wd_src", wd_src, 3'b000);
        chk("addi_wb_pcw", {pc_write, pc_src}, 3'b100);
        next_cycle();
        chk("addi_back_fetch", state, 1);

        // beq x0,x0,8 taken
        fetch(32'h0000_0463);
        next_cycle();
        br_taken = 1'b1;
        #1;
        chk("beq_t_pcw", pc_write, 1);
        chk("beq_t_pcsrc", pc_src, 2'b01);
        chk("beq_t_regw", reg_write, 0);
        chk("beq_t_alu", alu_ctr, 4'b1000);
        chk("beq_t_imm", imm_src, 3'b010);
        next_cycle();
        br_taken = 1'b0;
        chk("beq_t_fetch", state, 1);

        // beq not taken
        fetch(32'h0000_0463);
        next_cycle();
        chk("beq_nt_pc", {pc_write, pc_src}, 3'b100);
        next_cycle();
        chk("beq_nt_fetch", state, 1);

        // jal x1,16
        fetch(32'h0100_00EF);
        next_cycle();
        chk("jal_ctl", {reg_write, wd_src, pc_write, pc_src}, {1'b1, 3'b001, 1'b1, 2'b01});
        next_cycle();
        chk("jal_fetch", state, 1);

        // jalr x1,0(x2)
        fetch(32'h0001_00E7);
        next_cycle();
        chk("jalr_ctl", {reg_write, wd_src, pc_write, pc_src}, {1'b1, 3'b001, 1'b1, 2'b10});
        next_cycle();

        // lui / auipc writeback select
        fetch(32'h1234_50B7);
        next_cycle();
        next_cycle();
        chk("lui_wd", {reg_write, wd_src}, {1'b1, 3'b010});
        next_cycle();
        fetch(32'h0000_0097);
        next_cycle();
        next_cycle();
        chk("auipc_wd", {reg_write, wd_src}, {1'b1, 3'b011});
        next_cycle();

        // lw x1,0(x2): ready after 3 wait cycles, response after 2
        fetch(32'h0001_2083);
        next_cycle();
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            dmem_req_ready = (i == 3);
            #1;
            chk("lw_req_state", state, 4);
            chk("lw_req_valid", dmem_req_valid, 1);
            chk("lw_req_op", {mem_write, mem_op}, {1'b0, 3'b010});
            next_cycle();
        end
        dmem_req_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            dmem_resp_valid = (j == 2);
            #1;
            chk("lw_wait_state", state, 5);
            chk("lw_wait_reqv", dmem_req_valid, 0);
            chk("lw_wait_regw", reg_write, (j == 2) ? 1 : 0);
            chk("lw_wait_wd", wd_src, (j == 2) ? 3'b100 : 3'b000);
            next_cycle();
        end
        dmem_resp_valid = 1'b0;
        chk("lw_fetch", state, 1);

        // sw x1,0(x2), zero-wait
        fetch(32'h0011_2023);
        next_cycle();
        next_cycle();
        dmem_req_ready = 1'b1;
        #1;
        chk("sw_req", {dmem_req_valid, mem_write, mem_op}, {1'b1, 1'b1, 3'b010});
        chk("sw_pcw", {pc_write, reg_write}, 2'b10);
        next_cycle();
        dmem_req_ready = 1'b0;
        chk("sw_fetch", state, 1);

        // Fetch handshake on the limit cycle wins over the timeout
        for (int i = 0; i < 7; i++) next_cycle();
        fetch(32'h0050_0093);
        chk("limit_hs_state", state, 2);
        chk("limit_hs_buserr", bus_err, 0);
        next_cycle();
        next_cycle();
        next_cycle();

        // Fetch timeout
        for (int i = 0; i < 8; i++) begin
            chk("to_wait_state", state, 1);
            next_cycle();
        end
        chk("to_halt_state", state, 7);
        chk("to_buserr", bus_err, 1);
        imem_resp_valid = 1'b1;
        #1;
        chk("to_halt_ignored", {imem_req_valid, ir_write}, 0);
        next_cycle();
        imem_resp_valid = 1'b0;
        next_cycle();
        chk("to_halt_sticky", {state, bus_err}, {4'd7, 1'b1});

        // ebreak
        do_reset();
        chk("rst2_flags", {halt, illegal, bus_err}, 0);
        fetch(32'h0010_0073);
        chk("ebk_dec_en", {reg_write, pc_write}, 0);
        next_cycle();
        chk("ebk_halt", {state, halt, illegal}, {4'd7, 1'b1, 1'b0});
        chk("ebk_en", {reg_write, pc_write}, 0);

        // all-ones instruction
        do_reset();
        chk("rst3_flags", {halt, illegal, bus_err}, 0);
        fetch(32'hFFFF_FFFF);
        chk("ill_dec_en", {reg_write, pc_write}, 0);
        next_cycle();
        chk("ill_halt", {state, halt, illegal}, {4'd7, 1'b0, 1'b1});
        next_cycle();
        chk("ill_en", {reg_write, pc_write, imem_req_valid}, 0);

        // Reset during sw MEM_REQ
        do_reset();
        fetch(32'h0011_2023);
        next_cycle();
        next_cycle();
        chk("swr_req", {state, dmem_req_valid}, {4'd4, 1'b1});
        rst = 1'b1;
        #1;
        chk("swr_abort", {state, dmem_req_valid, mem_write}, {4'd0, 1'b0, 1'b0});
        next_cycle();
        chk("swr_hold", state, 0);
        rst = 1'b0;
        next_cycle();
        chk("swr_fetch", state, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
